cfg_spi_loader: RTL and testbench

Serial configuration front end for the synth core. Receives SPI-style frames (CS_N/SCK/SDI) on asynchronous pins, assembles bytes and issues byte-wide writes on the core's configuration write port (`cfg_we`, `cfg_w_addr`, `cfg_w_data`). It sits directly upstream of the config register file. It defers to sweep write-overrides through a `busy` stall input, so no write is lost to a collision.

---
 rtl/cfg_loader_pkg.sv | 18 +
 rtl/cfg_spi_loader_pin_sync.sv | 34 +++
 rtl/cfg_spi_loader.sv | 135 +++++++++++++
 tb/tb_cfg_spi_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the serial configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  // Header byte: [7] burst, [ADDR_BITS:1] word address, [0] byte select
  localparam int HDR_BURST = 7;
  localparam int HDR_SEL   = 0;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/cfg_spi_loader_pin_sync.sv
// Multi-flop pin synchronizer with one extra history flop for edge detection.
// Latency: STAGES cycles to level; rise/fall are valid in the same cycle as the new level.
// Backpressure: none; free-running every clock.
module pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the async pin through the chain; prev keeps last cycle's synced level
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/cfg_spi_loader.sv
// SPI-style frame receiver issuing byte-wide writes into the config register file.
// Latency: SYNC_STAGES+1 cycles from the 8th SCK pin edge of a byte to cfg_we (busy low).
// Backpressure: busy stalls the single pending write; a byte arriving behind it is dropped and flagged.
module cfg_spi_loader
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_BITS   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_n_raw,
  input  logic                 sck_raw,
  input  logic                 sdi_raw,
  input  logic                 busy,
  output logic [1:0]           cfg_we,
  output logic [ADDR_BITS-1:0] cfg_w_addr,
  output logic [15:0]          cfg_w_data,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int PW = ADDR_BITS + 1;    // byte pointer = {word addr, byte sel}
  localparam int CW = $clog2(BYTE_W);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .pin(cs_n_raw),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .pin(sck_raw),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .clk(clk), .reset(reset), .pin(sdi_raw),
    .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  // Only CS edges, SCK rise and the SDI level drive the receiver
  logic unused_pins;
  assign unused_pins = &{1'b0, cs_lvl, sck_lvl, sck_fall, sdi_rise, sdi_fall};

  state_t              state, state_nxt;
  logic [CW-1:0]       bit_cnt;
  logic [BYTE_W-2:0]   shreg;
  logic                burst;
  logic [PW-1:0]       bptr;
  logic                pending;
  logic [PW-1:0]       pend_ptr;
  logic [BYTE_W-1:0]   pend_byte;

  logic                sck_ok, byte_done, fire, trunc;
  logic [BYTE_W-1:0]   new_byte;

  // SCK edges only count inside a frame; CS_N falling lands us in HEADER, so it wins over SCK
  assign sck_ok    = sck_rise & (state != IDLE);
  assign byte_done = sck_ok & (bit_cnt == CW'(BYTE_W - 1));
  assign new_byte  = {shreg, sdi_lvl};
  assign fire      = pending & ~busy;
  // A frame ending on a byte boundary in DATA is clean; anything else partial is an error
  assign trunc     = cs_rise & ~byte_done &
                     ((state == HEADER) | ((state == DATA) & ((bit_cnt != '0) | sck_ok)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: CS_N rising always ends the frame; a full header moves into DATA
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = HEADER;
      HEADER:  if (cs_rise) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port driven straight from the pending buffer; addr/data hold after the write
  always_comb begin
    cfg_we = '0;
    if (fire) cfg_we[pend_ptr[0]] = 1'b1;
    cfg_w_addr = pend_ptr[PW-1:1];
    cfg_w_data = {pend_byte, pend_byte};
  end

  // Shift register, bit counter, byte pointer, pending buffer and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      burst     <= 1'b0;
      bptr      <= '0;
      pending   <= 1'b0;
      pend_ptr  <= '0;
      pend_byte <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= trunc;
      if (fire) pending <= 1'b0;
      if (cs_fall && state == IDLE) begin
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (sck_ok) begin
        shreg   <= new_byte[BYTE_W-2:0];
        bit_cnt <= bit_cnt + CW'(1);
        if (byte_done && state == HEADER) begin
          burst <= new_byte[HDR_BURST];
          bptr  <= {new_byte[ADDR_BITS:1], new_byte[HDR_SEL]};
        end
        if (byte_done && state == DATA) begin
          // A slot freed by this cycle's write can take the new byte straight away
          if (pending && !fire) begin
            overrun <= 1'b1;
          end else begin
            pending   <= 1'b1;
            pend_ptr  <= bptr;
            pend_byte <= new_byte;
          end
          if (burst) bptr <= bptr + PW'(1);
        end
      end
      if (cs_rise) bit_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_spi_loader.sv
// Randomized and directed bench for cfg_spi_loader against a frame-level write model.
// Latency: n/a.
// Backpressure: busy is driven either from a forced value or a bounded random pattern.
`timescale 1ns/1ps
module tb_cfg_spi_loader;

  localparam int AB   = 3;
  localparam int NPTR = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs_n_raw = 1'b1;
  logic          sck_raw = 1'b0;
  logic          sdi_raw = 1'b0;
  logic          busy = 1'b0;
  logic [1:0]    cfg_we;
  logic [AB-1:0] cfg_w_addr;
  logic [15:0]   cfg_w_data;
  logic          frame_err;
  logic          overrun;

  cfg_spi_loader #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs_n_raw(cs_n_raw), .sck_raw(sck_raw),
    .sdi_raw(sdi_raw), .busy(busy), .cfg_we(cfg_we), .cfg_w_addr(cfg_w_addr),
    .cfg_w_data(cfg_w_data), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [1:0]  we;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got_q[$];
  logic [7:0] tx_bytes[$];

  int total = 0, bad = 0, cyc = 0;
  int wr_count = 0, ferr_seen = 0, exp_ferr = 0;
  int last_we_cyc = -1, last_rise_cyc = 0, busy_run = 0;
  logic [AB-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;
  logic          prev_ferr = 1'b0;
  bit rand_busy = 1'b0, busy_force = 1'b0, chk_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // busy: forced value, or random with stalls capped well below one byte time
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_busy) begin
        if (busy_run >= 6) busy = 1'b0;
        else busy = ($urandom_range(0, 2) == 0);
        busy_run = busy ? busy_run + 1 : 0;
      end else begin
        busy = busy_force;
        busy_run = 0;
      end
    end
  end

  // Compare process: every write must match the model's next expected write
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      exp_q.delete();
      last_addr = '0;
      last_data = '0;
      prev_ferr = 1'b0;
    end else begin
      if (busy) chk("we_while_busy", cfg_we, 2'b00);
      if (cfg_we != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", cfg_we, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("write_we", cfg_we, e.we);
          chk("write_addr", cfg_w_addr, e.addr);
          chk("write_data", cfg_w_data, e.d);
        end
        e.addr = int'(cfg_w_addr);
        e.we   = cfg_we;
        e.d    = cfg_w_data;
        got_q.push_back(e);
        last_addr   = cfg_w_addr;
        last_data   = cfg_w_data;
        last_we_cyc = cyc;
        wr_count++;
      end else if (exp_q.size() == 0) begin
        chk("hold_addr", cfg_w_addr, last_addr);
        chk("hold_data", cfg_w_data, last_data);
      end
      if (frame_err) begin
        chk("frame_err_width", prev_ferr, 1'b0);
        ferr_seen++;
      end
      prev_ferr = frame_err;
      if (chk_ovr) chk("overrun_clear", overrun, 1'b0);
    end
  end

  task automatic spi_bit(input logic b);
    sdi_raw = b;
    sck_raw = 1'b0;
    tick(4);
    sck_raw = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
  endtask

  // One frame: hbits header bits, then tx_bytes (first `keep` expected to be written),
  // then tbits stray bits. rel>0 releases busy_force rel cycles after the last byte's SCK edge.
  task automatic send_frame(input logic [7:0] hdr, input int hbits, input int tbits,
                            input int keep, input int rel);
    int ptr;
    logic [7:0] d;
    wr_t w;
    ptr = int'(hdr) % NPTR;
    cs_n_raw = 1'b0;
    tick(6);
    for (int i = 0; i < hbits; i++) spi_bit(hdr[7-i]);
    if (hbits < 8) begin
      exp_ferr++;
    end else begin
      for (int k = 0; k < tx_bytes.size(); k++) begin
        d = tx_bytes[k];
        if (k < keep) begin
          w.addr = ptr / 2;
          w.we   = (ptr % 2 == 1) ? 2'b10 : 2'b01;
          w.d    = {d, d};
          exp_q.push_back(w);
        end
        if (hdr[7]) ptr = (ptr + 1) % NPTR;
        for (int i = 0; i < 8; i++) spi_bit(d[7-i]);
      end
      if (rel > 0) begin
        while (cyc < last_rise_cyc + rel) tick(1);
        busy_force = 1'b0;
      end
      for (int i = 0; i < tbits; i++) spi_bit(1'($urandom));
      if (tbits > 0) exp_ferr++;
    end
    sck_raw = 1'b0;
    tick(4);
    cs_n_raw = 1'b1;
    tick(10);
  endtask

  initial begin
    int wc, fe, p, hb, tb, nb;
    logic [7:0] hdr;

    // Reset state
    reset = 1'b1;
    tick(3);
    chk("rst_we", cfg_we, 2'b00);
    chk("rst_addr", cfg_w_addr, 3'd0);
    chk("rst_data", cfg_w_data, 16'h0000);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single write: header 0x05 -> addr 2, sel 1
    wc = wr_count;
    tx_bytes.delete(); tx_bytes.push_back(8'hA7);
    send_frame(8'h05, 8, 0, 1, 0);
    chk("single_count", wr_count - wc, 1);
    chk("single_latency", last_we_cyc - last_rise_cyc, 3);
    chk("single_we", got_q[$].we, 2'b10);
    chk("single_addr", got_q[$].addr, 2);
    chk("single_data", got_q[$].d, 16'hA7A7);
    chk("single_no_ferr", ferr_seen, 0);

    // Burst wrapping from byte pointer 15 to 0
    wc = wr_count;
    tx_bytes.delete(); tx_bytes.push_back(8'h11); tx_bytes.push_back(8'h22);
    send_frame(8'h8F, 8, 0, 2, 0);
    chk("burst_count", wr_count - wc, 2);
    chk("burst0_addr", got_q[$-1].addr, 7);
    chk("burst0_we", got_q[$-1].we, 2'b10);
    chk("burst0_data", got_q[$-1].d, 16'h1111);
    chk("burst1_addr", got_q[$].addr, 0);
    chk("burst1_we", got_q[$].we, 2'b01);
    chk("burst1_data", got_q[$].d, 16'h2222);

    // busy stall: pending rises 3 cycles after the edge, busy covers 5 cycles from there
    busy_force = 1'b1;
    tick(1);
    wc = wr_count;
    tx_bytes.delete(); tx_bytes.push_back(8'h5A);
    send_frame(8'h04, 8, 0, 1, 8);
    chk("stall_count", wr_count - wc, 1);
    chk("stall_latency", last_we_cyc - last_rise_cyc, 8);
    chk("stall_data", got_q[$].d, 16'h5A5A);

    // Overrun: second byte lands while the first is still stalled
    busy_force = 1'b1;
    tick(1);
    wc = wr_count;
    tx_bytes.delete(); tx_bytes.push_back(8'h33); tx_bytes.push_back(8'h44);
    send_frame(8'h80, 8, 0, 1, 0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_no_write_yet", wr_count - wc, 0);
    busy_force = 1'b0;
    tick(5);
    chk("ovr_count", wr_count - wc, 1);
    chk("ovr_addr", got_q[$].addr, 0);
    chk("ovr_we", got_q[$].we, 2'b01);
    chk("ovr_data", got_q[$].d, 16'h3333);
    chk("ovr_sticky", overrun, 1'b1);
    cs_n_raw = 1'b0;
    tick(6);
    chk("ovr_cleared_by_cs", overrun, 1'b0);
    tx_bytes.delete(); tx_bytes.push_back(8'h55);
    send_frame(8'h00, 8, 0, 1, 0);

    // Truncated frames: partial data byte, and a frame with no header bits at all
    wc = wr_count; fe = ferr_seen;
    tx_bytes.delete();
    send_frame(8'h02, 8, 3, 0, 0);
    chk("trunc_ferr", ferr_seen - fe, 1);
    chk("trunc_no_write", wr_count - wc, 0);
    fe = ferr_seen;
    send_frame(8'h00, 0, 0, 0, 0);
    chk("empty_hdr_ferr", ferr_seen - fe, 1);

    // SCK activity with CS_N high is ignored; a following frame decodes normally
    wc = wr_count; fe = ferr_seen;
    for (int i = 0; i < 10; i++) spi_bit(1'($urandom));
    sck_raw = 1'b0;
    tick(8);
    chk("idle_sck_no_write", wr_count - wc, 0);
    chk("idle_sck_no_ferr", ferr_seen - fe, 0);
    tx_bytes.delete(); tx_bytes.push_back(8'hC3);
    send_frame(8'h0B, 8, 0, 1, 0);
    chk("after_idle_addr", got_q[$].addr, 5);
    chk("after_idle_data", got_q[$].d, 16'hC3C3);

    // Reset while a write is pending behind busy
    busy_force = 1'b1;
    tick(1);
    tx_bytes.delete(); tx_bytes.push_back(8'h99);
    send_frame(8'h06, 8, 0, 1, 0);
    reset = 1'b1;
    tick(2);
    chk("rstp_we", cfg_we, 2'b00);
    chk("rstp_addr", cfg_w_addr, 3'd0);
    chk("rstp_data", cfg_w_data, 16'h0000);
    chk("rstp_frame_err", frame_err, 1'b0);
    chk("rstp_overrun", overrun, 1'b0);
    wc = wr_count;
    reset = 1'b0;
    busy_force = 1'b0;
    tick(20);
    chk("rstp_no_write", wr_count - wc, 0);

    // Random frames with bounded random busy
    rand_busy = 1'b1;
    chk_ovr = 1'b1;
    for (int f = 0; f < 30; f++) begin
      hdr = 8'($urandom);
      hb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 8;
      nb  = $urandom_range(0, 4);
      tb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      tx_bytes.delete();
      for (int k = 0; k < nb; k++) tx_bytes.push_back(8'($urandom));
      send_frame(hdr, hb, tb, nb, 0);
    end
    rand_busy = 1'b0;
    chk_ovr = 1'b0;
    tick(20);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_ferr_count", ferr_seen, exp_ferr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
